// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch address/instruction geometry and a NOP encoding.
package cpu_pkg;

   // Word-address width; must match the instruction memory address port.
   localparam int unsigned PC_W = 10;
   // Instruction width.
   localparam int unsigned INSTR_W = 32;
   // PC loaded on reset.
   localparam logic [PC_W-1:0] RESET_PC = '0;
   // No-op encoding, reserved for decode to inject into squashed slots.
   localparam logic [INSTR_W-1:0] NOP = '0;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid buffer: captures the memory word on the first stall cycle and
// keeps presenting it until cleared, so the memory is free to re-read the PC.
module fetch_hold_reg
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              clear,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              sel
);

   logic [DATA_W-1:0] data_q;
   logic              sel_q;

   // Capture only once per stall; later stall cycles must not overwrite the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= 1'b0;
      end else if (clear) begin
         sel_q <= 1'b0;
      end else if (capture && !sel_q) begin
         data_q <= data_in;
         sel_q  <= 1'b1;
      end
   end

   assign data_out = data_q;
   assign sel      = sel_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tags memory words with their address,
// absorbs decode stalls through a hold register and squashes on redirect.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned      PC_W     = cpu_pkg::PC_W,
   parameter int unsigned      INSTR_W  = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0]  RESET_PC = cpu_pkg::RESET_PC,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] ins_in,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic [PC_W-1:0]    id_pc_next,
   output logic               id_valid,
   output logic [CNT_W-1:0]   fetch_count
);

   logic [PC_W-1:0]    pc_reg;
   logic [PC_W-1:0]    id_pc_reg;
   logic               id_valid_reg;
   logic [CNT_W-1:0]   cnt;
   logic [INSTR_W-1:0] hold_data;
   logic               hold_sel;
   logic               hold_capture;
   logic               hold_clear;
   logic               delivered;

   // Redirect beats stall; any non-stall edge releases the held word.
   assign hold_capture = stall && !redirect;
   assign hold_clear   = redirect || !stall;
   assign delivered    = id_valid_reg && !stall && !redirect;

   fetch_hold_reg #(
      .DATA_W (INSTR_W)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .capture  (hold_capture),
      .clear    (hold_clear),
      .data_in  (ins_in),
      .data_out (hold_data),
      .sel      (hold_sel)
   );

   // PC and ID tag: redirect squashes, stall freezes, otherwise advance one word.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg       <= RESET_PC;
         id_pc_reg    <= '0;
         id_valid_reg <= 1'b0;
      end else if (redirect) begin
         pc_reg       <= redirect_pc;
         id_valid_reg <= 1'b0;
      end else if (!stall) begin
         id_pc_reg    <= pc_reg;
         id_valid_reg <= 1'b1;
         pc_reg       <= pc_reg + 1'b1;
      end
   end

   // Saturating count of instructions actually accepted by decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (delivered && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Bubbles read as zero; during a stall the held copy replaces the live word.
   always_comb begin
      id_instr = '0;
      if (id_valid_reg) begin
         id_instr = hold_sel ? hold_data : ins_in;
      end
   end

   assign pc          = pc_reg;
   assign id_pc       = id_pc_reg;
   assign id_pc_next  = id_pc_reg + 1'b1;
   assign id_valid    = id_valid_reg;
   assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [9:0]  redirect_pc;
   logic [9:0]  pc;
   logic [31:0] ins_in;
   logic [31:0] id_instr;
   logic [9:0]  id_pc;
   logic [9:0]  id_pc_next;
   logic        id_valid;
   logic [15:0] fetch_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [9:0]  rpc;
      logic        valid;
      logic [9:0]  idpc;
      logic [9:0]  pc;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .ins_in      (ins_in),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_next  (id_pc_next),
      .id_valid    (id_valid),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Memory contents: 0x28011DD0 @0, 0x28021DD1 @1, ...
   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return 32'h28001DD0 + ({22'd0, a} + 32'd1 << 16) + {22'd0, a};
   endfunction

   // Registered-read memory: word appears one edge after its address.
   always @(posedge clk) ins_in <= mem_word(pc);

   function automatic vec_t mk(input logic r, input logic s, input logic d, input int rp,
                               input logic v, input int ip, input int p, input int c);
      vec_t x;
      x.rst = r; x.stall = s; x.redir = d; x.rpc = 10'(rp);
      x.valid = v; x.idpc = 10'(ip); x.pc = 10'(p); x.cnt = 16'(c);
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst = v.rst; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      chk("pc", {22'd0, pc}, {22'd0, e.pc});
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, e.cnt});
      if (e.valid) begin
         chk("id_instr", id_instr, mem_word(e.idpc));
      end else begin
         chk("id_instr_bubble", id_instr, 32'd0);
      end
      if (e.valid || e.rst) begin
         chk("id_pc", {22'd0, id_pc}, {22'd0, e.idpc});
         chk("id_pc_next", {22'd0, id_pc_next}, {22'd0, 10'(e.idpc + 10'd1)});
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

      //                 rst stl rd rpc   valid idpc  pc    cnt
      tbl.push_back(mk(1, 0, 0, 0,    0, 0,    0,    0));
      tbl.push_back(mk(1, 0, 0, 0,    0, 0,    0,    0));
      tbl.push_back(mk(0, 0, 0, 0,    1, 0,    1,    0));
      tbl.push_back(mk(0, 0, 0, 0,    1, 1,    2,    1));
      tbl.push_back(mk(0, 0, 0, 0,    1, 2,    3,    2));
      tbl.push_back(mk(0, 0, 1, 8,    0, 2,    8,    2));   // squash id_pc=2
      tbl.push_back(mk(0, 0, 0, 0,    1, 8,    9,    2));
      tbl.push_back(mk(0, 0, 0, 0,    1, 9,    10,   3));
      tbl.push_back(mk(0, 1, 0, 0,    1, 9,    10,   3));   // hold captures @9
      tbl.push_back(mk(0, 1, 1, 4,    0, 9,    4,    3));   // redirect beats stall
      tbl.push_back(mk(0, 0, 0, 0,    1, 4,    5,    3));   // stale hold would show @9
      tbl.push_back(mk(0, 1, 0, 0,    1, 4,    5,    3));
      tbl.push_back(mk(0, 1, 0, 0,    1, 4,    5,    3));
      tbl.push_back(mk(0, 1, 0, 0,    1, 4,    5,    3));
      tbl.push_back(mk(0, 0, 0, 0,    1, 5,    6,    4));   // no bubble, id_pc=4 once
      tbl.push_back(mk(0, 0, 0, 0,    1, 6,    7,    5));
      tbl.push_back(mk(0, 0, 1, 20,   0, 6,    20,   5));
      tbl.push_back(mk(0, 1, 0, 0,    0, 6,    20,   5));   // stalled bubble
      tbl.push_back(mk(0, 0, 0, 0,    1, 20,   21,   5));
      tbl.push_back(mk(0, 0, 0, 0,    1, 21,   22,   6));
      tbl.push_back(mk(0, 0, 1, 1022, 0, 21,   1022, 6));
      tbl.push_back(mk(0, 0, 0, 0,    1, 1022, 1023, 6));
      tbl.push_back(mk(0, 0, 0, 0,    1, 1023, 0,    7));   // id_pc_next wraps to 0
      tbl.push_back(mk(0, 0, 0, 0,    1, 0,    1,    8));
      tbl.push_back(mk(0, 0, 0, 0,    1, 1,    2,    9));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Reset asserted mid-stall, then clean restart.
      step(mk(0, 1, 0, 0, 1, 1, 2, 9));
      step(mk(1, 1, 0, 0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 1, 0, 1, 0));

      // Saturation: run free until the counter sits at 0xFFFE, then deliver three more.
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; redirect = 1'b0;
      repeat (65533) @(posedge clk);
      step(mk(0, 0, 0, 0, 1, 1022, 1023, 16'hFFFE));
      step(mk(0, 0, 0, 0, 1, 1023, 0,    16'hFFFF));
      step(mk(0, 0, 0, 0, 1, 0,    1,    16'hFFFF));
      step(mk(0, 0, 0, 0, 1, 1,    2,    16'hFFFF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
